// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg: shared state encoding, pixel/column types and column slot indices
// for the line-buffer sequencer.
package line_buffer_pkg;

   localparam int PXL_CHANNEL_DEF = 8;

   localparam int COL_TOP = 2;
   localparam int COL_MID = 1;
   localparam int COL_BOT = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } lb_state_e;

   typedef logic [2:0][PXL_CHANNEL_DEF-1:0] pixel_t;
   typedef pixel_t [2:0] column_t;

endpackage

// File: rtl/line_buffer_ctrl_raster_counter.sv
// raster_counter: x/y position of the next raster pixel, with frame-restart preload,
// row/frame wrap and synchronous clear.
module raster_counter #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int AW         = 10,
   parameter int YW         = 9
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clr,
   input  logic          i_restart,
   input  logic          i_adv,
   output logic [AW-1:0] o_x,
   output logic [YW-1:0] o_y,
   output logic          o_last,
   output logic          o_eol
);

   logic [AW-1:0] r_x, w_x_base, w_x_nxt;
   logic [YW-1:0] r_y, w_y_base, w_y_nxt;

   // A restart treats the current beat as pixel (0,0) before advancing past it.
   always_comb begin
      w_x_base = r_x;
      w_y_base = r_y;
      w_x_nxt  = r_x;
      w_y_nxt  = r_y;
      if (i_restart) begin
         w_x_base = {AW{1'b0}};
         w_y_base = {YW{1'b0}};
      end else begin
         w_x_base = r_x;
         w_y_base = r_y;
      end
      if (i_clr) begin
         w_x_nxt = {AW{1'b0}};
         w_y_nxt = {YW{1'b0}};
      end else if (i_adv) begin
         if (w_x_base == AW'(IMG_WIDTH - 1)) begin
            w_x_nxt = {AW{1'b0}};
            if (w_y_base == YW'(IMG_HEIGHT - 1)) begin
               w_y_nxt = {YW{1'b0}};
            end else begin
               w_y_nxt = w_y_base + YW'(1);
            end
         end else begin
            w_x_nxt = w_x_base + AW'(1);
            w_y_nxt = w_y_base;
         end
      end else begin
         w_x_nxt = w_x_base;
         w_y_nxt = w_y_base;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x <= {AW{1'b0}};
         r_y <= {YW{1'b0}};
      end else begin
         r_x <= w_x_nxt;
         r_y <= w_y_nxt;
      end
   end

   assign o_x    = r_x;
   assign o_y    = r_y;
   assign o_eol  = (r_x == AW'(IMG_WIDTH - 1));
   assign o_last = o_eol && (r_y == YW'(IMG_HEIGHT - 1));

endmodule

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequences two cascaded line RAMs and emits one vertical 3-pixel column
// per accepted pixel. Macro LB_CTRL_DRAIN_EN adds a DRAIN pass that flushes the last row.
module line_buffer_ctrl
   import line_buffer_pkg::*;
#(
   parameter int  PXL_CHANNEL = PXL_CHANNEL_DEF,
   parameter int  IMG_WIDTH   = 640,
   parameter int  IMG_HEIGHT  = 480,
   localparam int AW          = $clog2(IMG_WIDTH),
   localparam int YW          = $clog2(IMG_HEIGHT),
   localparam int PYW         = YW + 1
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_valid,
   input  logic                               i_sof,
   input  logic [2:0][PXL_CHANNEL-1:0]        i_pixel,
   output logic                               o_ready,
   output logic                               o_lb0_we,
   output logic [AW-1:0]                      o_lb0_waddr,
   output logic [2:0][PXL_CHANNEL-1:0]        o_lb0_wdata,
   output logic                               o_lb1_we,
   output logic [AW-1:0]                      o_lb1_waddr,
   output logic [2:0][PXL_CHANNEL-1:0]        o_lb1_wdata,
   output logic [AW-1:0]                      o_rd_addr,
   input  logic [2:0][PXL_CHANNEL-1:0]        i_lb0_rdata,
   input  logic [2:0][PXL_CHANNEL-1:0]        i_lb1_rdata,
   output logic                               o_col_valid,
   output logic [2:0][2:0][PXL_CHANNEL-1:0]   o_col,
   output logic [AW-1:0]                      o_col_x,
   output logic [YW-1:0]                      o_col_y,
   output logic                               o_eol,
   output logic                               o_frame_done,
   output logic                               o_err
);

   lb_state_e r_state, w_state_nxt;

   logic w_acc, w_pix_acc, w_drain_px, w_restart, w_err;
   logic w_adv, w_clr, w_last, w_eol_x, w_frame_end, w_col_ok;
   logic [AW-1:0] w_cnt_x, w_px;
   logic [YW-1:0] w_cnt_y, w_py;

   logic                        r_p_valid;
   logic                        r_p_last;
   logic [AW-1:0]               r_p_x;
   logic [PYW-1:0]              r_p_y;
   logic [2:0][PXL_CHANNEL-1:0] r_p_pix;

   assign o_ready = (r_state != DRAIN);
   assign w_acc   = i_valid & o_ready;

   raster_counter #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT),
      .AW         (AW),
      .YW         (YW)
   ) u_raster_counter (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clr     (w_clr),
      .i_restart (w_restart),
      .i_adv     (w_adv),
      .o_x       (w_cnt_x),
      .o_y       (w_cnt_y),
      .o_last    (w_last),
      .o_eol     (w_eol_x)
   );

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and per-beat control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_pix_acc   = 1'b0;
      w_drain_px  = 1'b0;
      w_restart   = 1'b0;
      w_err       = 1'b0;
      w_adv       = 1'b0;
      w_clr       = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_acc && i_sof) begin
               w_pix_acc   = 1'b1;
               w_restart   = 1'b1;
               w_adv       = 1'b1;
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (w_acc && i_sof) begin
               w_pix_acc   = 1'b1;
               w_restart   = 1'b1;
               w_adv       = 1'b1;
               w_err       = 1'b1;
               w_state_nxt = RUN;
            end else if (w_acc) begin
               w_pix_acc = 1'b1;
               w_adv     = 1'b1;
               if (w_last) begin
`ifdef LB_CTRL_DRAIN_EN
                  w_state_nxt = DRAIN;
`else
                  w_state_nxt = IDLE;
`endif
               end else begin
                  w_state_nxt = RUN;
               end
            end else begin
               w_state_nxt = RUN;
            end
         end
         DRAIN: begin
            w_drain_px = 1'b1;
            w_adv      = 1'b1;
            if (w_eol_x) begin
               w_clr       = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = DRAIN;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign w_px = w_restart ? {AW{1'b0}} : w_cnt_x;
   assign w_py = w_restart ? {YW{1'b0}} : w_cnt_y;

`ifdef LB_CTRL_DRAIN_EN
   assign w_frame_end = w_drain_px & w_eol_x;
`else
   assign w_frame_end = w_pix_acc & ~w_restart & w_last;
`endif

   assign o_lb0_we    = w_pix_acc;
   assign o_lb0_waddr = w_px;
   assign o_lb0_wdata = i_pixel;
   assign o_rd_addr   = w_px;

   assign o_lb1_we    = r_p_valid;
   assign o_lb1_waddr = r_p_x;
   assign o_lb1_wdata = i_lb0_rdata;

   // Stage P: holds the accepted (or drain) pixel while the RAM read returns.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_p_valid <= 1'b0;
         r_p_last  <= 1'b0;
         r_p_x     <= {AW{1'b0}};
         r_p_y     <= {PYW{1'b0}};
         r_p_pix   <= '0;
      end else begin
         r_p_valid <= w_pix_acc | w_drain_px;
         r_p_last  <= w_frame_end;
         r_p_x     <= w_px;
         r_p_y     <= w_drain_px ? PYW'(IMG_HEIGHT) : {1'b0, w_py};
         r_p_pix   <= w_drain_px ? '0 : i_pixel;
      end
   end

   // A restart kills the old frame's column still sitting in stage P.
   assign w_col_ok = r_p_valid & (r_p_y >= PYW'(2)) & ~w_err;

   // Output column register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_col_valid  <= 1'b0;
         o_col        <= '0;
         o_col_x      <= {AW{1'b0}};
         o_col_y      <= {YW{1'b0}};
         o_eol        <= 1'b0;
         o_frame_done <= 1'b0;
         o_err        <= 1'b0;
      end else begin
         o_col_valid      <= w_col_ok;
         o_col[COL_TOP]   <= i_lb1_rdata;
         o_col[COL_MID]   <= i_lb0_rdata;
         o_col[COL_BOT]   <= r_p_pix;
         o_col_x          <= r_p_x;
         o_col_y          <= YW'(r_p_y - PYW'(1));
         o_eol            <= w_col_ok & (r_p_x == AW'(IMG_WIDTH - 1));
         o_frame_done     <= w_col_ok & r_p_last;
         o_err            <= w_err;
      end
   end

endmodule
